// File: rtl/rename_checkpoint_unit.sv
// ---------------------------------------------------------------------------
// rename_checkpoint_unit
// Single-issue register renamer sitting between decode and the instruction
// queue. Maps architectural to physical registers through the RMT, hands out
// physical registers from a circular free list, records each displaced
// mapping in an active list so it can be freed at commit, tracks per-phys
// busy bits, and snapshots rename state per branch for one-cycle recovery.
//
// Ports
//   clk, rst              clock / synchronous active-high reset
//   ren_valid/ren_ready   rename handshake with decode
//   ren_uses_rw           instruction writes ren_rw_arch
//   ren_is_branch         instruction needs a checkpoint
//   ren_rs/rt/rw_arch     source / destination architectural registers
//   ren_rs/rt_phys        current mappings of the sources (combinational)
//   ren_rs/rt_busy        busy bits of those mappings, writeback-bypassed
//   ren_rw_phys           free-list head (register allocated on accept)
//   ren_old_phys          mapping of ren_rw_arch before this rename
//   ren_ckpt_id           checkpoint slot a branch would receive
//   wb_valid/wb_phys      writeback clears the busy bit of wb_phys
//   commit_valid          retire the active-list head
//   br_valid/br_mispredict/br_ckpt_id  branch resolution (oldest checkpoint)
//   al_empty              active list holds no instructions
// ---------------------------------------------------------------------------
module rename_checkpoint_unit #(
   parameter int ARCH_REGS = 32,
   parameter int PHYS_REGS = 64,
   parameter int AL_DEPTH  = 32,
   parameter int CKPTS     = 4,
   localparam int AW = $clog2(ARCH_REGS),
   localparam int PW = $clog2(PHYS_REGS),
   localparam int CW = $clog2(CKPTS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ren_valid,
   output logic          ren_ready,
   input  logic          ren_uses_rw,
   input  logic          ren_is_branch,
   input  logic [AW-1:0] ren_rs_arch,
   input  logic [AW-1:0] ren_rt_arch,
   input  logic [AW-1:0] ren_rw_arch,
   output logic [PW-1:0] ren_rs_phys,
   output logic [PW-1:0] ren_rt_phys,
   output logic          ren_rs_busy,
   output logic          ren_rt_busy,
   output logic [PW-1:0] ren_rw_phys,
   output logic [PW-1:0] ren_old_phys,
   output logic [CW-1:0] ren_ckpt_id,
   input  logic          wb_valid,
   input  logic [PW-1:0] wb_phys,
   input  logic          commit_valid,
   input  logic          br_valid,
   input  logic          br_mispredict,
   input  logic [CW-1:0] br_ckpt_id,
   output logic          al_empty
);

   localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
   localparam int FW       = $clog2(FL_DEPTH);
   localparam int LW       = $clog2(AL_DEPTH);

   // Ring pointers carry one extra wrap bit so occupancy is simply tail-head,
   // which also makes the free-list count exact after a checkpoint restore.
   // Depths are assumed to be powers of two.
   logic [PW-1:0] rmt_reg        [ARCH_REGS];
   logic          busy_reg       [PHYS_REGS];
   logic [PW-1:0] fl_mem_reg     [FL_DEPTH];
   logic [FW:0]   fl_head_reg, fl_tail_reg, fl_head_next, fl_tail_next;
   logic          al_has_rw_reg  [AL_DEPTH];
   logic [PW-1:0] al_old_reg     [AL_DEPTH];
   logic [LW:0]   al_head_reg, al_tail_reg, al_head_next, al_tail_next;
   logic [PW-1:0] ck_rmt_reg     [CKPTS][ARCH_REGS];
   logic [FW:0]   ck_fl_head_reg [CKPTS];
   logic [LW:0]   ck_al_tail_reg [CKPTS];
   logic [CW:0]   ck_head_reg, ck_tail_reg, ck_head_next, ck_tail_next;

   logic [FW:0]   fl_count;
   logic [LW:0]   al_count;
   logic [CW:0]   ck_count;
   logic [CW-1:0] ck_slot, ck_rel;
   logic          do_mispredict, do_release, accept, do_alloc, do_ckpt;
   logic          do_commit, commit_frees, wb_hit;

   assign fl_count = fl_tail_reg - fl_head_reg;
   assign al_count = al_tail_reg - al_head_reg;
   assign ck_count = ck_tail_reg - ck_head_reg;
   assign ck_slot  = ck_tail_reg[CW-1:0];

   assign do_mispredict = br_valid & br_mispredict;
   assign do_release    = br_valid & ~br_mispredict & (ck_count != '0);
   assign ren_ready     = (fl_count != '0)
                        & (al_count != (LW+1)'(AL_DEPTH))
                        & (~ren_is_branch | (ck_count != (CW+1)'(CKPTS)))
                        & ~do_mispredict;
   assign accept        = ren_valid & ren_ready;
   assign do_alloc      = accept & ren_uses_rw & (ren_rw_arch != '0);
   assign do_ckpt       = accept & ren_is_branch;
   assign do_commit     = commit_valid & (al_count != '0);
   assign commit_frees  = do_commit & al_has_rw_reg[al_head_reg[LW-1:0]];
   assign wb_hit        = wb_valid & (wb_phys != '0);

   // Lookups: sources see the pre-rename RMT, so rs==rw reads the old mapping.
   assign ren_rs_phys  = rmt_reg[ren_rs_arch];
   assign ren_rt_phys  = rmt_reg[ren_rt_arch];
   assign ren_rs_busy  = busy_reg[ren_rs_phys] & ~(wb_hit & (wb_phys == ren_rs_phys));
   assign ren_rt_busy  = busy_reg[ren_rt_phys] & ~(wb_hit & (wb_phys == ren_rt_phys));
   assign ren_rw_phys  = fl_mem_reg[fl_head_reg[FW-1:0]];
   assign ren_old_phys = rmt_reg[ren_rw_arch];
   assign ren_ckpt_id  = ck_slot;
   assign al_empty     = (al_count == '0);

   // Distance from the oldest live checkpoint to the mispredicted one; every
   // checkpoint from that one onward is discarded.
   assign ck_rel = br_ckpt_id - ck_head_reg[CW-1:0];

   always_comb begin
      fl_head_next = fl_head_reg + {{FW{1'b0}}, do_alloc};
      al_tail_next = al_tail_reg + {{LW{1'b0}}, accept};
      ck_tail_next = ck_tail_reg + {{CW{1'b0}}, do_ckpt};
      if (do_mispredict) begin
         fl_head_next = ck_fl_head_reg[br_ckpt_id];
         al_tail_next = ck_al_tail_reg[br_ckpt_id];
         ck_tail_next = ck_head_reg + {1'b0, ck_rel};
      end
      fl_tail_next = fl_tail_reg + {{FW{1'b0}}, commit_frees};
      al_head_next = al_head_reg + {{LW{1'b0}}, do_commit};
      ck_head_next = ck_head_reg + {{CW{1'b0}}, do_release};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fl_head_reg <= '0;
         fl_tail_reg <= (FW+1)'(FL_DEPTH);
         al_head_reg <= '0;
         al_tail_reg <= '0;
         ck_head_reg <= '0;
         ck_tail_reg <= '0;
      end else begin
         fl_head_reg <= fl_head_next;
         fl_tail_reg <= fl_tail_next;
         al_head_reg <= al_head_next;
         al_tail_reg <= al_tail_next;
         ck_head_reg <= ck_head_next;
         ck_tail_reg <= ck_tail_next;
      end
   end

   // Free list: freed registers are appended at the tail; reset loads the
   // registers above the architectural range in ascending order.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FL_DEPTH; i++) fl_mem_reg[i] <= PW'(ARCH_REGS + i);
      end else if (commit_frees) begin
         fl_mem_reg[fl_tail_reg[FW-1:0]] <= al_old_reg[al_head_reg[LW-1:0]];
      end
   end

   // Active list and checkpoint side data need no reset: their pointers do.
   always_ff @(posedge clk) begin
      if (!rst && accept) begin
         al_has_rw_reg[al_tail_reg[LW-1:0]] <= do_alloc;
         al_old_reg[al_tail_reg[LW-1:0]]    <= ren_old_phys;
      end
      if (!rst && do_ckpt) begin
         ck_fl_head_reg[ck_slot] <= fl_head_next;
         ck_al_tail_reg[ck_slot] <= al_tail_next;
      end
   end

   generate
      for (genvar gi = 0; gi < ARCH_REGS; gi++) begin : g_rmt
         logic rw_hit;
         assign rw_hit = do_alloc & (ren_rw_arch == AW'(gi));

         always_ff @(posedge clk) begin
            if (rst)
               rmt_reg[gi] <= PW'(gi);
            else if (do_mispredict)
               rmt_reg[gi] <= ck_rmt_reg[br_ckpt_id][gi];
            else if (rw_hit)
               rmt_reg[gi] <= ren_rw_phys;
         end

         // Snapshot holds the RMT as it stands after the branch's own rename.
         for (genvar ci = 0; ci < CKPTS; ci++) begin : g_ck
            always_ff @(posedge clk) begin
               if (!rst && do_ckpt && (ck_slot == CW'(ci)))
                  ck_rmt_reg[ci][gi] <= rw_hit ? ren_rw_phys : rmt_reg[gi];
            end
         end
      end

      // Squashed registers keep a stale busy bit; it is re-set on reallocation.
      for (genvar gi = 0; gi < PHYS_REGS; gi++) begin : g_busy
         always_ff @(posedge clk) begin
            if (rst)
               busy_reg[gi] <= 1'b0;
            else if (do_alloc && (ren_rw_phys == PW'(gi)))
               busy_reg[gi] <= 1'b1;
            else if (wb_hit && (wb_phys == PW'(gi)))
               busy_reg[gi] <= 1'b0;
         end
      end
   endgenerate

endmodule
